// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad scanner and its consumers.
package lock_pkg;

   // Scanner FSM states.
   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_e;

   // Row drive patterns (active-low): first scanned row and all rows off.
   localparam logic [3:0] ROW_INIT = 4'b1110;
   localparam logic [3:0] ROW_IDLE = 4'b1111;

   // Field positions inside the conv8 key code.
   localparam int COL_LSB = 4;
   localparam int ROW_LSB = 0;

   // True when exactly one column is asserted.
   function automatic logic one_hot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   // The decoder expects col1 in the most significant column bit.
   function automatic logic [2:0] reverse3(input logic [2:0] v);
      return {v[0], v[1], v[2]};
   endfunction

   // Advance the one-cold row drive: row1 -> row2 -> row3 -> row4 -> row1.
   function automatic logic [3:0] rotate_row(input logic [3:0] r);
      return {r[2:0], r[3]};
   endfunction

   // Assemble the conv8 code from an active-high column and row.
   function automatic logic [7:0] make_code(input logic [2:0] col, input logic [3:0] row);
      logic [7:0] code;
      code                  = 8'h00;
      code[COL_LSB +: 3]    = reverse3(col);
      code[ROW_LSB +: 4]    = row;
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones so that
// idle (pulled-up) lines read as inactive straight out of reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: drives rows one-cold, synchronises the columns and
// debounces both press and release, reporting one conv8 code per press.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   SCAN     | dwell on the driven row, then look for a single active column
//   DEBOUNCE | candidate key latched; must stay identical for DEBOUNCE_CYC
//   HELD     | key reported; wait for every column to go quiet
//   RELEASE  | columns quiet; must stay quiet for DEBOUNCE_CYC
module keypad_scanner
   import lock_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CYC = 20000,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scan_en,
   input  logic [2:0] col_n,
   output logic [3:0] row_n,
   output logic [7:0] conv8,
   output logic       key_valid,
   output logic       key_busy
);

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);

   scan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       row_q, row_d;
   logic [3:0]       row_lat_q, row_lat_d;
   logic [2:0]       col_lat_q, col_lat_d;
   logic [7:0]       conv8_q, conv8_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   logic [2:0]       col_sync;
   logic [2:0]       col_s;

   sync_2ff #(.WIDTH(3)) u_col_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (col_n),
      .q_o   (col_sync)
   );

   // Columns are pulled up, so a pressed key reads high after inversion.
   assign col_s = ~col_sync;

   // State, counter, row drive and reported key registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SCAN;
         cnt_q     <= '0;
         row_q     <= ROW_INIT;
         row_lat_q <= 4'b0000;
         col_lat_q <= 3'b000;
         conv8_q   <= 8'h00;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         row_q     <= row_d;
         row_lat_q <= row_lat_d;
         col_lat_q <= col_lat_d;
         conv8_q   <= conv8_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state, counter and output decisions.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      row_lat_d = row_lat_q;
      col_lat_d = col_lat_q;
      conv8_d   = conv8_q;
      valid_d   = 1'b0;
      busy_d    = busy_q;

      if (!scan_en) begin
         // Disable wins over everything, including an acceptance this cycle.
         state_d = SCAN;
         cnt_d   = '0;
         row_d   = ROW_IDLE;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            SCAN: begin
               if (row_q == ROW_IDLE) begin
                  // First enabled cycle after a disable: restart on row1.
                  row_d = ROW_INIT;
                  cnt_d = '0;
               end else if (cnt_q == SCAN_LAST) begin
                  cnt_d = '0;
                  if (one_hot3(col_s)) begin
                     row_lat_d = ~row_q;
                     col_lat_d = col_s;
                     state_d   = DEBOUNCE;
                  end else begin
                     // Nothing or ghosting/multi-key: keep looking.
                     row_d = rotate_row(row_q);
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            DEBOUNCE: begin
               if (col_s != col_lat_q) begin
                  state_d = SCAN;
                  row_d   = rotate_row(row_q);
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  conv8_d = make_code(col_lat_q, row_lat_q);
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  state_d = HELD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            HELD: begin
               // Extra keys while held are ignored; only full release counts.
               cnt_d = '0;
               if (col_s == 3'b000) begin
                  state_d = RELEASE;
               end
            end

            RELEASE: begin
               if (col_s != 3'b000) begin
                  cnt_d = '0;
               end else if (cnt_q == DEB_LAST) begin
                  busy_d  = 1'b0;
                  row_d   = rotate_row(row_q);
                  cnt_d   = '0;
                  state_d = SCAN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            default: begin
               state_d = SCAN;
               cnt_d   = '0;
               row_d   = ROW_INIT;
            end
         endcase
      end
   end

   assign row_n     = row_q;
   assign conv8     = conv8_q;
   assign key_valid = valid_q;
   assign key_busy  = busy_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the columns from
// the row drive; a behavioural model predicts every output each cycle.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;

   localparam int HUNT     = 0;
   localparam int CONFIRM  = 1;
   localparam int HOLD     = 2;
   localparam int WAIT_REL = 3;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b1;
   logic        scan_en = 1'b0;
   logic [11:0] pressed = 12'h000;   // index = row*3 + col, rows/cols from 0
   logic [2:0]  col_n;
   logic [3:0]  row_n;
   logic [7:0]  conv8;
   logic        key_valid;
   logic        key_busy;

   int n_checks = 0;
   int n_pass   = 0;
   int dut_pulses = 0;
   logic [7:0] dut_last = 8'h00;

   // model state
   int   m_phase = HUNT;
   int   m_ri = 0;
   bit   m_idle = 1'b0;
   int   m_t = 0;
   int   m_lr = 0;
   int   m_lc = 0;
   logic [7:0] m_code = 8'h00;
   bit   m_valid = 1'b0;
   bit   m_busy = 1'b0;
   logic [2:0] m_hist0 = 3'b111;
   logic [2:0] m_hist1 = 3'b111;
   bit   rst_seen = 1'b0;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEB), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scan_en   (scan_en),
      .col_n     (col_n),
      .row_n     (row_n),
      .conv8     (conv8),
      .key_valid (key_valid),
      .key_busy  (key_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] keypad_cols(input logic [11:0] p, input logic [3:0] rn);
      logic [2:0] pulled;
      pulled = 3'b000;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (p[r*3+c] && !rn[r]) pulled[c] = 1'b1;
      return ~pulled;
   endfunction

   assign col_n = keypad_cols(pressed, row_n);

   function automatic logic [3:0] m_row();
      logic [3:0] onehot;
      if (m_idle) return 4'b1111;
      onehot = 4'b0001 << m_ri;
      return ~onehot;
   endfunction

   task automatic model_reset();
      m_phase = HUNT; m_ri = 0; m_idle = 1'b0; m_t = 0;
      m_lr = 0; m_lc = 0; m_code = 8'h00; m_valid = 1'b0; m_busy = 1'b0;
      m_hist0 = 3'b111; m_hist1 = 3'b111;
      rst_seen = 1'b1;
   endtask

   task automatic model_step();
      logic [2:0] seen;
      seen    = ~m_hist1;          // columns as seen two clocks late
      m_hist1 = m_hist0;
      m_hist0 = col_n;
      m_valid = 1'b0;
      if (!scan_en) begin
         m_phase = HUNT; m_t = 0; m_idle = 1'b1; m_busy = 1'b0;
      end else begin
         case (m_phase)
            HUNT: begin
               if (m_idle) begin
                  m_idle = 1'b0; m_ri = 0; m_t = 0;
               end else if (m_t == SCAN_DIV - 1) begin
                  m_t = 0;
                  if ($countones(seen) == 1) begin
                     m_lr = m_ri;
                     for (int c = 0; c < 3; c++) if (seen[c]) m_lc = c;
                     m_phase = CONFIRM;
                  end else begin
                     m_ri = (m_ri + 1) % 4;
                  end
               end else begin
                  m_t++;
               end
            end
            CONFIRM: begin
               if (int'(seen) != (1 << m_lc)) begin
                  m_phase = HUNT; m_ri = (m_ri + 1) % 4; m_t = 0;
               end else if (m_t == DEB - 1) begin
                  m_code  = (8'h40 >> m_lc) | (8'h01 << m_lr);
                  m_valid = 1'b1; m_busy = 1'b1; m_phase = HOLD; m_t = 0;
               end else begin
                  m_t++;
               end
            end
            HOLD: begin
               m_t = 0;
               if (seen == 3'b000) m_phase = WAIT_REL;
            end
            default: begin
               if (seen != 3'b000) m_t = 0;
               else if (m_t == DEB - 1) begin
                  m_busy = 1'b0; m_ri = (m_ri + 1) % 4; m_t = 0; m_phase = HUNT;
               end else m_t++;
            end
         endcase
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Per-cycle comparison against the model, plus pulse bookkeeping.
   initial forever begin
      @(negedge clk);
      if (rst_seen) begin
         check("row_n", {28'd0, row_n}, {28'd0, m_row()});
         check("conv8", {24'd0, conv8}, {24'd0, m_code});
         check("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
         check("key_busy", {31'd0, key_busy}, {31'd0, m_busy});
         if (key_valid === 1'b1) begin
            dut_pulses++;
            dut_last = conv8;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic wait_pulses(input int target, input string name);
      int k;
      k = 0;
      while (dut_pulses < target && k < 300) begin
         tick(1);
         k++;
      end
      check(name, dut_pulses, target);
   endtask

   task automatic press(input int r, input int c, input bit v);
      pressed[r*3+c] = v;
   endtask

   initial begin
      int base;
      int k;
      int hold;
      int r1, c1, r2, c2;

      // 1: reset and row rotation
      scan_en = 1'b1;
      #1 rst_n = 1'b0;
      tick(3);
      check("rst row_n", {28'd0, row_n}, 32'h0000_000E);
      check("rst conv8", {24'd0, conv8}, 32'h0);
      check("rst key_valid", {31'd0, key_valid}, 32'h0);
      check("rst key_busy", {31'd0, key_busy}, 32'h0);
      rst_n = 1'b1;
      tick(3);
      check("rot row1 dwell", {28'd0, row_n}, 32'h0000_000E);
      tick(1);
      check("rot row2", {28'd0, row_n}, 32'h0000_000D);
      tick(4);
      check("rot row3", {28'd0, row_n}, 32'h0000_000B);

      // 2: key 5 steady
      base = dut_pulses;
      press(1, 1, 1'b1);
      wait_pulses(base + 1, "key5 pulse");
      check("key5 code", {24'd0, dut_last}, 32'h22);
      check("model key5 code", {24'd0, m_code}, 32'h22);
      tick(20);
      check("key5 single", dut_pulses, base + 1);
      check("key5 busy held", {31'd0, key_busy}, 32'h1);
      press(1, 1, 1'b0);
      tick(4);
      check("key5 busy after rel", {31'd0, key_busy}, 32'h1);
      tick(10);
      check("key5 busy cleared", {31'd0, key_busy}, 32'h0);
      tick(10);

      // 3: key 1 bouncing
      base = dut_pulses;
      for (int i = 0; i < 10; i++) begin
         pressed[0] = ~pressed[0];
         tick(3);
      end
      check("bounce no pulse", dut_pulses, base);
      press(0, 0, 1'b1);
      wait_pulses(base + 1, "key1 pulse");
      check("key1 code", {24'd0, dut_last}, 32'h41);
      press(0, 0, 1'b0);
      tick(25);

      // 4: keys 4 and 5 together, then release 4
      base = dut_pulses;
      press(1, 0, 1'b1);
      press(1, 1, 1'b1);
      tick(60);
      check("multi no pulse", dut_pulses, base);
      press(1, 0, 1'b0);
      wait_pulses(base + 1, "multi->key5 pulse");
      check("multi->key5 code", {24'd0, dut_last}, 32'h22);
      press(1, 1, 1'b0);
      tick(25);

      // 5: key 0 held long, released, pressed again
      base = dut_pulses;
      press(3, 1, 1'b1);
      tick(200);
      check("key0 no repeat", dut_pulses, base + 1);
      check("key0 code a", {24'd0, dut_last}, 32'h28);
      press(3, 1, 1'b0);
      tick(25);
      press(3, 1, 1'b1);
      wait_pulses(base + 2, "key0 second pulse");
      check("key0 code b", {24'd0, dut_last}, 32'h28);
      press(3, 1, 1'b0);
      tick(25);

      // 6: key *, disable during debounce, then reset while held
      base = dut_pulses;
      press(3, 2, 1'b1);
      k = 0;
      while (m_phase != CONFIRM && k < 200) begin tick(1); k++; end
      check("star reached debounce", {31'd0, (m_phase == CONFIRM)}, 32'h1);
      scan_en = 1'b0;
      tick(3);
      check("disabled row_n", {28'd0, row_n}, 32'h0000_000F);
      tick(10);
      check("disabled no pulse", dut_pulses, base);
      scan_en = 1'b1;
      wait_pulses(base + 1, "star pulse");
      check("star code", {24'd0, dut_last}, 32'h18);
      tick(3);
      check("star busy", {31'd0, key_busy}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid rst row_n", {28'd0, row_n}, 32'h0000_000E);
      check("mid rst conv8", {24'd0, conv8}, 32'h0);
      check("mid rst busy", {31'd0, key_busy}, 32'h0);
      tick(2);
      rst_n = 1'b1;
      wait_pulses(base + 2, "star after reset");
      check("star code after reset", {24'd0, dut_last}, 32'h18);
      press(3, 2, 1'b0);
      tick(25);

      // Randomised presses, multi-key, bounce and enable drops
      for (int it = 0; it < 30; it++) begin
         r1 = $urandom_range(0, 3); c1 = $urandom_range(0, 2);
         r2 = $urandom_range(0, 3); c2 = $urandom_range(0, 2);
         hold = $urandom_range(5, 90);
         press(r1, c1, 1'b1);
         if ($urandom_range(0, 4) == 0) press(r2, c2, 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            for (int b = 0; b < 4; b++) begin
               pressed[r1*3+c1] = ~pressed[r1*3+c1];
               tick($urandom_range(1, 5));
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            tick(hold / 2);
            scan_en = 1'b0;
            tick($urandom_range(1, 6));
            scan_en = 1'b1;
            tick(hold / 2);
         end else begin
            tick(hold);
         end
         pressed = 12'h000;
         tick($urandom_range(0, 40));
      end
      tick(30);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4x3 lock keypad matrix: scans rows, samples and synchronises columns, debounces presses and releases.
- Emits one 8-bit row/column code per debounced press in the conv8 format consumed by the keypad decoder, with a 1-cycle valid strobe.
- Sits between the keypad pins and the decoder/lock FSM.
- Only controller of the keypad resource: one key reported per physical press, no auto-repeat.

Parameters:
- SCAN_DIV, 1000, clk cycles each row is driven before its columns are sampled (>=4).
- DEBOUNCE_CYC, 20000, consecutive stable clk cycles required to accept a press or a release (>=2).
- CNT_W, 16, counter width; must hold max(SCAN_DIV, DEBOUNCE_CYC)-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- scan_en  in  1  1 = scanning enabled.
- col_n  in  3  keypad columns, active-low, externally pulled up, asynchronous. col_n[0]=col1, col_n[2]=col3.
- row_n  out  4  row drive, active-low, one-cold. row_n[0]=row1 (keys 1,2,3), row_n[3]=row4 (keys #,0,*).
- conv8  out  8  last accepted key code {1'b0, col3..col1 at bits 6..4, row4..row1 at bits 3..0}.
  - col1 maps to bit6, col3 to bit4.
  - Example: key 5 = 8'b0010_0010.
- key_valid  out  1  1-cycle pulse; conv8 is new this cycle.
- key_busy  out  1  high from press acceptance until release is debounced.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled by top level):
  - row_n=4'b1110, conv8=8'h00, key_valid=0, key_busy=0.
  - state=SCAN, counter=0, latched row/col=0, synchroniser flops=3'b111.
- Column path: col_n goes through a 2-FF synchroniser. col_s = ~sync output, active-high. All decisions use col_s.
- SCAN:
  - Counter increments each cycle.
  - At counter==SCAN_DIV-1, col_s is evaluated:
    - exactly one-hot: latch current row and col_s, counter=0, go to DEBOUNCE; row_n holds.
    - zero or multi-hot: rotate row_n 1110->1101->1011->0111->1110, counter=0.
  - The dwell provides settling time and covers synchroniser latency.
- DEBOUNCE:
  - row_n held. Each cycle, if col_s != latched col: go to SCAN, rotate row, counter=0.
  - Otherwise the counter increments. At counter==DEBOUNCE_CYC-1:
    - conv8 <= {1'b0, latched col reversed into bits 6..4, latched row one-hot in bits 3..0}.
    - key_valid=1 for exactly that one cycle; key_busy=1; go to HELD.
- HELD:
  - row_n held, counter=0.
  - col_s==0 -> RELEASE. Any nonzero col_s, including extra keys, stays in HELD. No further strobes.
- RELEASE:
  - col_s==0 increments the counter; col_s!=0 clears the counter and stays in RELEASE (bounce).
  - At counter==DEBOUNCE_CYC-1: key_busy=0, rotate row, counter=0, go to SCAN.
- scan_en=0, from any state, next cycle:
  - state=SCAN, counter=0, row_n=4'b1111, key_busy=0, key_valid=0. conv8 holds.
  - On scan_en rising, row_n=4'b1110 and scanning restarts at row1 with counter=0.
- Simultaneous events:
  - scan_en=0 overrides all transitions, including the acceptance cycle: no strobe is issued.
  - Reset asserted in any state returns to reset values immediately. A key still held after reset must be fully re-debounced and is then reported once.
- Latency:
  - From a stable press on the driven row, key_valid follows at most SCAN_DIV + DEBOUNCE_CYC + 2 cycles after the row becomes active.
  - Worst case from an arbitrary phase: 4*SCAN_DIV + DEBOUNCE_CYC + 2.
- Counter never wraps. Every state resets it on a transition.

Decomposition:
- Shared package lock_pkg:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE}.
  - ROW_INIT=4'b1110, ROW_IDLE=4'b1111.
  - conv8 field positions (COL_LSB=4, ROW_LSB=0).
- One sub-module: sync_2ff (parameterised width, async active-low reset to all-ones) for col_n.
- The FSM, counter and row rotator stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8; keypad model pulls col_n[c] low while row_n[r]==0 for each pressed key):
1. Hold rst_n=0 for 3 cycles, scan_en=1 -> row_n=1110, conv8=00, key_valid=0, key_busy=0. After release, row_n rotates every 4 cycles.
2. Press key 5 (row2/col2) steadily -> exactly one key_valid pulse with conv8=8'h22. key_busy stays high until 8 cycles after release; then row rotation resumes.
3. Press key 1 bouncing (toggle every 3 cycles for 30 cycles, then stable) -> exactly one pulse with conv8=8'h41, none during the bounce.
4. Keys 4 and 5 held simultaneously (row2, col1+col2) -> no key_valid, row_n keeps rotating. Release 4 -> one pulse with conv8=8'h22.
5. Key 0 held 200 cycles, released, pressed again -> two pulses total, both conv8=8'h28, no repeat while held.
6. Key * held:
   - Drop scan_en in DEBOUNCE -> row_n=1111, no pulse.
   - Re-enable -> one pulse with conv8=8'h18.
   - Then assert rst_n=0 in HELD -> immediate reset values, followed by one fresh pulse with conv8=8'h18 after the press is re-debounced.
